// File: rtl/ps2_key_note_pkg.sv
// Shared constants and helpers for the PS/2 receiver and key tracker.
package ps2_key_note_pkg;

  localparam logic [7:0]  PS2_BREAK  = 8'hF0;
  localparam logic [7:0]  PS2_EXT    = 8'hE0;
  localparam int unsigned FRAME_BITS = 11;
  localparam int unsigned CNT_W      = 4;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RECV = 1'b1;

  // Odd parity over data+parity and a high stop bit make a good frame.
  function automatic logic frame_ok(input logic [7:0] data, input logic parity,
                                    input logic stop);
    return (^{data, parity}) & stop;
  endfunction

endpackage

// File: rtl/ps2_scan_ascii.sv
// Set-2 make code to ASCII lookup: a-z, 0-9 and space; everything else maps to 0.
module ps2_scan_ascii (
  input  logic [7:0] scan_i,
  output logic [7:0] ascii_c
);

  always_comb begin
    ascii_c = 8'h00;
    case (scan_i)
      8'h1C: ascii_c = 8'h61;  8'h32: ascii_c = 8'h62;  8'h21: ascii_c = 8'h63;
      8'h23: ascii_c = 8'h64;  8'h24: ascii_c = 8'h65;  8'h2B: ascii_c = 8'h66;
      8'h34: ascii_c = 8'h67;  8'h33: ascii_c = 8'h68;  8'h43: ascii_c = 8'h69;
      8'h3B: ascii_c = 8'h6A;  8'h42: ascii_c = 8'h6B;  8'h4B: ascii_c = 8'h6C;
      8'h3A: ascii_c = 8'h6D;  8'h31: ascii_c = 8'h6E;  8'h44: ascii_c = 8'h6F;
      8'h4D: ascii_c = 8'h70;  8'h15: ascii_c = 8'h71;  8'h2D: ascii_c = 8'h72;
      8'h1B: ascii_c = 8'h73;  8'h2C: ascii_c = 8'h74;  8'h3C: ascii_c = 8'h75;
      8'h2A: ascii_c = 8'h76;  8'h1D: ascii_c = 8'h77;  8'h22: ascii_c = 8'h78;
      8'h35: ascii_c = 8'h79;  8'h1A: ascii_c = 8'h7A;
      8'h45: ascii_c = 8'h30;  8'h16: ascii_c = 8'h31;  8'h1E: ascii_c = 8'h32;
      8'h26: ascii_c = 8'h33;  8'h25: ascii_c = 8'h34;  8'h2E: ascii_c = 8'h35;
      8'h36: ascii_c = 8'h36;  8'h3D: ascii_c = 8'h37;  8'h3E: ascii_c = 8'h38;
      8'h46: ascii_c = 8'h39;  8'h29: ascii_c = 8'h20;
      default: ascii_c = 8'h00;
    endcase
  end

endmodule

// File: rtl/ps2_key_note.sv
// PS/2 frame receiver with make/break/extended decoding; presents the held key
// as a set-2 scan code and its ASCII value (0 = nothing held).
module ps2_key_note
  import ps2_key_note_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] ascll,
  output logic [7:0] scan_code,
  output logic       key_down,
  output logic       key_event,
  output logic       frame_err
);

  localparam int unsigned      TMO_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic clk_s1_q, clk_s2_q, clk_prev_q, dat_s1_q, dat_s2_q;
  logic fall_q, bit_q;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_q, par_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [7:0]       byte_q, byte_d;
  logic             byte_rdy_q, byte_rdy_d;
  logic             frame_err_q, frame_err_d;

  logic             brk_q, brk_d, ext_q, ext_d;
  logic [7:0]       scan_q, scan_d, ascll_q, ascll_d;
  logic             key_down_q, key_down_d, key_event_q, key_event_d;
  logic [7:0]       ascii_c;

  // Two-flop synchronizers, then a registered falling-edge strobe with aligned data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_s1_q   <= 1'b0;
      clk_s2_q   <= 1'b0;
      clk_prev_q <= 1'b0;
      dat_s1_q   <= 1'b0;
      dat_s2_q   <= 1'b0;
      fall_q     <= 1'b0;
      bit_q      <= 1'b0;
    end else begin
      clk_s1_q   <= ps2_clk;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      dat_s1_q   <= ps2_data;
      dat_s2_q   <= dat_s1_q;
      fall_q     <= clk_prev_q & ~clk_s2_q;
      bit_q      <= dat_s2_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      tmo_q       <= '0;
      byte_q      <= '0;
      byte_rdy_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      tmo_q       <= tmo_d;
      byte_q      <= byte_d;
      byte_rdy_q  <= byte_rdy_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Frame FSM: start, 8 data bits LSB first, parity, stop; idle timer saturates.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    par_d       = par_q;
    byte_d      = byte_q;
    byte_rdy_d  = 1'b0;
    frame_err_d = 1'b0;
    tmo_d       = tmo_q;

    if (fall_q)                 tmo_d = '0;
    else if (tmo_q != TMO_LAST) tmo_d = tmo_q + TMO_W'(1);

    if (state_q == ST_IDLE) begin
      if (fall_q) begin
        if (!bit_q) begin
          state_d = ST_RECV;
          cnt_d   = CNT_W'(1);
        end else begin
          frame_err_d = 1'b1;
        end
      end
    end else begin
      if (fall_q) begin
        if (cnt_q <= CNT_W'(FRAME_BITS - 3)) begin
          shift_d = {bit_q, shift_q[7:1]};
          cnt_d   = cnt_q + CNT_W'(1);
        end else if (cnt_q == CNT_W'(FRAME_BITS - 2)) begin
          par_d = bit_q;
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          if (frame_ok(shift_q, par_q, bit_q)) begin
            byte_rdy_d = 1'b1;
            byte_d     = shift_q;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end else if (tmo_q == TMO_LAST) begin
        state_d     = ST_IDLE;
        cnt_d       = '0;
        frame_err_d = 1'b1;
      end
    end
  end

  ps2_scan_ascii u_lookup (
    .scan_i  (byte_q),
    .ascii_c (ascii_c)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      brk_q       <= 1'b0;
      ext_q       <= 1'b0;
      scan_q      <= '0;
      ascll_q     <= '0;
      key_down_q  <= 1'b0;
      key_event_q <= 1'b0;
    end else begin
      brk_q       <= brk_d;
      ext_q       <= ext_d;
      scan_q      <= scan_d;
      ascll_q     <= ascll_d;
      key_down_q  <= key_down_d;
      key_event_q <= key_event_d;
    end
  end

  // Key decoder: prefixes set flags; a new mapped make overrides, repeats are dropped.
  always_comb begin
    brk_d       = brk_q;
    ext_d       = ext_q;
    scan_d      = scan_q;
    ascll_d     = ascll_q;
    key_down_d  = key_down_q;
    key_event_d = 1'b0;

    if (byte_rdy_q) begin
      if (byte_q == PS2_BREAK) begin
        brk_d = 1'b1;
      end else if (byte_q == PS2_EXT) begin
        ext_d = 1'b1;
      end else if (ext_q) begin
        ext_d = 1'b0;
        brk_d = 1'b0;
      end else if (brk_q) begin
        brk_d = 1'b0;
        if (key_down_q && (byte_q == scan_q)) begin
          key_down_d  = 1'b0;
          scan_d      = '0;
          ascll_d     = '0;
          key_event_d = 1'b1;
        end
      end else if ((ascii_c != 8'h00) && !(key_down_q && (byte_q == scan_q))) begin
        key_down_d  = 1'b1;
        scan_d      = byte_q;
        ascll_d     = ascii_c;
        key_event_d = 1'b1;
      end
    end
  end

  assign ascll     = ascll_q;
  assign scan_code = scan_q;
  assign key_down  = key_down_q;
  assign key_event = key_event_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_key_note.sv
// Bench for ps2_key_note: directed vector table, timing/corner sequences, and
// randomized byte streams checked against a key-state reference model.
module tb_ps2_key_note;

  localparam int unsigned TMO  = 200;
  localparam int          HALF = 16;
  localparam int          GAP  = 20;

  logic       clk = 1'b0;
  logic       reset_n, ps2_clk, ps2_data;
  logic [7:0] ascll, scan_code;
  logic       key_down, key_event, frame_err;

  always #5 clk = ~clk;

  ps2_key_note #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .ascll     (ascll),
    .scan_code (scan_code),
    .key_down  (key_down),
    .key_event (key_event),
    .frame_err (frame_err)
  );

  int checks = 0, errors = 0, ev_cnt = 0, err_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic bad_par);
    return {1'b1, (~^b) ^ bad_par, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      tick(HALF);
      ps2_clk = 1'b0;
      tick(HALF);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par);
    send_bits(mk_frame(b, bad_par), 11);
    ps2_data = 1'b1;
    tick(GAP);
  endtask

  // Pulse monitor: counts events, checks width/exclusivity and that ascll moves only on key_event.
  logic       prev_ke = 1'b0;
  logic [7:0] prev_ascll = 8'h00;
  always begin
    @(posedge clk);
    #1;
    if (reset_n !== 1'b1) begin
      prev_ke    = 1'b0;
      prev_ascll = 8'h00;
    end else begin
      if (key_event === 1'b1) begin
        ev_cnt++;
        check("ke_vs_frame_err", 32'(frame_err), 0);
        check("ke_width", 32'(prev_ke), 0);
      end
      if (frame_err === 1'b1) err_cnt++;
      if (ascll !== prev_ascll) check("ascll_change_needs_event", 32'(key_event), 1);
      prev_ke    = key_event;
      prev_ascll = ascll;
    end
  end

  // Reference model: ASCII map and the spec's key-tracking rules.
  logic [7:0] amap [256];
  logic [7:0] codes [37] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                             8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                             8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A,
                             8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E,
                             8'h46, 8'h29};
  string      keys = "abcdefghijklmnopqrstuvwxyz0123456789 ";
  logic [7:0] m_held;
  logic       m_brk, m_ext;
  int         m_ev, m_err;

  task automatic model_byte(input logic [7:0] b, input logic bad);
    if (bad) m_err++;
    else if (b == 8'hF0) m_brk = 1'b1;
    else if (b == 8'hE0) m_ext = 1'b1;
    else if (m_ext) begin m_ext = 1'b0; m_brk = 1'b0; end
    else if (m_brk) begin
      m_brk = 1'b0;
      if (m_held != 8'h00 && b == m_held) begin m_held = 8'h00; m_ev++; end
    end else if (amap[b] != 8'h00 && b != m_held) begin
      m_held = b;
      m_ev++;
    end
  endtask

  typedef struct {
    logic [7:0] b;
    logic       bad;
    logic [7:0] exp_a;
    logic [7:0] exp_s;
    logic       exp_kd;
    int         ev;
    int         er;
  } vec_t;
  vec_t vt[$];

  task automatic add(input logic [7:0] b, input logic bad, input logic [7:0] a,
                     input logic [7:0] s, input logic kd, input int ev, input int er);
    vec_t v;
    v.b = b; v.bad = bad; v.exp_a = a; v.exp_s = s; v.exp_kd = kd; v.ev = ev; v.er = er;
    vt.push_back(v);
  endtask

  task automatic check_outs(input string tag, input logic [7:0] a, input logic [7:0] s,
                            input logic kd);
    check({tag, "_ascll"}, 32'(ascll), 32'(a));
    check({tag, "_scan"}, 32'(scan_code), 32'(s));
    check({tag, "_key_down"}, 32'(key_down), 32'(kd));
  endtask

  initial begin
    int ev0, er0;
    logic [7:0] b;
    logic bad;
    logic [7:0] pool [6];

    pool = '{8'h1C, 8'h15, 8'h16, 8'h29, 8'h45, 8'h1A};
    for (int i = 0; i < 256; i++) amap[i] = 8'h00;
    for (int i = 0; i < 37; i++) amap[codes[i]] = keys[i];

    add(8'h1C,0, 8'h61,8'h1C,1, 1,0);  add(8'hF0,0, 8'h61,8'h1C,1, 0,0);
    add(8'h1C,0, 8'h00,8'h00,0, 1,0);  add(8'h1C,0, 8'h61,8'h1C,1, 1,0);
    add(8'h1C,0, 8'h61,8'h1C,1, 0,0);  add(8'h1C,0, 8'h61,8'h1C,1, 0,0);
    add(8'h15,0, 8'h71,8'h15,1, 1,0);  add(8'hF0,0, 8'h71,8'h15,1, 0,0);
    add(8'h1C,0, 8'h71,8'h15,1, 0,0);  add(8'h16,1, 8'h71,8'h15,1, 0,1);
    add(8'h16,0, 8'h31,8'h16,1, 1,0);  add(8'hE0,0, 8'h31,8'h16,1, 0,0);
    add(8'h75,0, 8'h31,8'h16,1, 0,0);  add(8'hF0,0, 8'h31,8'h16,1, 0,0);
    add(8'hE0,0, 8'h31,8'h16,1, 0,0);  add(8'h75,0, 8'h31,8'h16,1, 0,0);
    add(8'h05,0, 8'h31,8'h16,1, 0,0);  add(8'hF0,0, 8'h31,8'h16,1, 0,0);
    add(8'h16,0, 8'h00,8'h00,0, 1,0);  add(8'hE0,0, 8'h00,8'h00,0, 0,0);
    add(8'h75,0, 8'h00,8'h00,0, 0,0);  add(8'hF0,0, 8'h00,8'h00,0, 0,0);
    add(8'hE0,0, 8'h00,8'h00,0, 0,0);  add(8'h75,0, 8'h00,8'h00,0, 0,0);
    add(8'h05,0, 8'h00,8'h00,0, 0,0);  add(8'hE0,0, 8'h00,8'h00,0, 0,0);
    add(8'h1C,0, 8'h00,8'h00,0, 0,0);  add(8'h45,0, 8'h30,8'h45,1, 1,0);
    add(8'h29,0, 8'h20,8'h29,1, 1,0);  add(8'hF0,0, 8'h20,8'h29,1, 0,0);
    add(8'h45,0, 8'h20,8'h29,1, 0,0);  add(8'hF0,0, 8'h20,8'h29,1, 0,0);
    add(8'h29,0, 8'h00,8'h00,0, 1,0);

    reset_n = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
    tick(3);
    check_outs("reset", 8'h00, 8'h00, 1'b0);
    check("reset_key_event", 32'(key_event), 0);
    check("reset_frame_err", 32'(frame_err), 0);
    reset_n = 1'b1;
    tick(5);

    foreach (vt[i]) begin
      ev0 = ev_cnt; er0 = err_cnt;
      send_frame(vt[i].b, vt[i].bad);
      check_outs($sformatf("vec%0d", i), vt[i].exp_a, vt[i].exp_s, vt[i].exp_kd);
      check($sformatf("vec%0d_events", i), 32'(ev_cnt - ev0), 32'(vt[i].ev));
      check($sformatf("vec%0d_frame_errs", i), 32'(err_cnt - er0), 32'(vt[i].er));
    end

    // Latency from the raw stop-bit fall to key_event.
    ev0 = ev_cnt;
    send_bits(mk_frame(8'h45, 1'b0), 10);
    ps2_data = 1'b1;
    tick(HALF);
    ps2_clk = 1'b0;
    tick(4);
    check("lat4_key_event", 32'(key_event), 0);
    check("lat4_ascll", 32'(ascll), 32'h00);
    tick(1);
    check("lat5_key_event", 32'(key_event), 1);
    check("lat5_ascll", 32'(ascll), 32'h30);
    tick(HALF - 5);
    ps2_clk = 1'b1;
    tick(GAP);
    check("lat_events", 32'(ev_cnt - ev0), 1);

    // Bad start bit: a lone falling edge with data high.
    er0 = err_cnt;
    send_bits(11'h7FF, 1);
    tick(GAP);
    check("bad_start_errs", 32'(err_cnt - er0), 1);
    check("bad_start_ascll", 32'(ascll), 32'h30);

    // Timeout after 5 bits, then a full frame recovers.
    ev0 = ev_cnt; er0 = err_cnt;
    send_bits(mk_frame(8'h1C, 1'b0), 5);
    tick(TMO + 50);
    check("tmo_errs", 32'(err_cnt - er0), 1);
    check("tmo_events", 32'(ev_cnt - ev0), 0);
    tick(2 * TMO);
    check("tmo_errs_once", 32'(err_cnt - er0), 1);
    ps2_data = 1'b1;
    send_frame(8'h29, 1'b0);
    check_outs("after_tmo", 8'h20, 8'h29, 1'b1);

    // Reset in the middle of a frame.
    send_bits(mk_frame(8'h15, 1'b0), 5);
    reset_n = 1'b0;
    tick(2);
    check_outs("midreset", 8'h00, 8'h00, 1'b0);
    check("midreset_key_event", 32'(key_event), 0);
    check("midreset_frame_err", 32'(frame_err), 0);
    reset_n = 1'b1;
    ps2_data = 1'b1;
    tick(5);
    ev0 = ev_cnt;
    send_frame(8'h1C, 1'b0);
    check_outs("post_reset", 8'h61, 8'h1C, 1'b1);
    check("post_reset_events", 32'(ev_cnt - ev0), 1);

    // Randomized byte stream against the reference model.
    ev0 = ev_cnt; er0 = err_cnt;
    m_held = 8'h1C; m_brk = 1'b0; m_ext = 1'b0; m_ev = 0; m_err = 0;
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: b = pool[$urandom_range(0, 5)];
        5, 6:          b = 8'hF0;
        7:             b = 8'hE0;
        default:       b = 8'($urandom_range(0, 255));
      endcase
      bad = ($urandom_range(0, 9) == 0);
      send_frame(b, bad);
      model_byte(b, bad);
      check_outs($sformatf("rnd%0d", i), amap[m_held], m_held, m_held != 8'h00);
      check($sformatf("rnd%0d_events", i), 32'(ev_cnt - ev0), 32'(m_ev));
      check($sformatf("rnd%0d_frame_errs", i), 32'(err_cnt - er0), 32'(m_err));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_key_note.md
# ps2_key_note

PS/2 keyboard receiver and key-tracking stage that sits directly upstream of the frequency lookup in the sound path. It samples the raw `ps2_clk`/`ps2_data` lines in the 50 MHz domain and deframes 11-bit PS/2 frames. It then decodes make, break (F0) and extended (E0) sequences and presents the ASCII code of the currently held key on `ascll`; the next stage turns that code into a tone frequency. `ascll` reads 0 whenever no mapped key is held, which the downstream stage treats as silence.

## Interface
- `TIMEOUT_CYCLES`, default 50000: idle-`clk` cycles allowed between `ps2_clk` falling edges inside a frame (1 ms at 50 MHz).
- `clk` input 1: 50 MHz system clock (`CLOCK_50`); the only clock.
- `reset_n` input 1: asynchronous, active-low reset (driven from `KEY[0]`).
- `ps2_clk` input 1: raw keyboard clock, asynchronous to `clk`.
- `ps2_data` input 1: raw keyboard data, asynchronous to `clk`.
- `ascll` output 8: ASCII code of the held key; 0 when no key is held.
- `scan_code` output 8: set-2 make code of the held key; 0 when no key is held.
- `key_down` output 1: level, 1 while a mapped key is held.
- `key_event` output 1: one-cycle pulse on every accepted press or release.
- `frame_err` output 1: one-cycle pulse on a bad start, parity or stop bit, or on a timeout.

## Operation
- Input conditioning: each of `ps2_clk` and `ps2_data` passes through a 2-FF synchronizer. A falling edge is `prev & ~cur` on the synchronized clock.
- Frame FSM:
  - IDLE: on a falling edge, sample data as the start bit. Data 0 → RECV with bit count 1. Data 1 → pulse `frame_err` and stay in IDLE.
  - RECV: on each falling edge, shift in data, LSB first, for bits 1..8. Bit 9 is parity and bit 10 is stop.
  - Frame check after bit 10: data plus parity must have odd weight, and stop must be 1. Pass → one-cycle `byte_rdy` with the byte. Fail → pulse `frame_err` and discard. Either way → IDLE.
  - Timeout: a counter clears on every falling edge. In RECV, when it reaches `TIMEOUT_CYCLES - 1`, pulse `frame_err`, discard the partial frame and return to IDLE.
- Key decoder, processing each `byte_rdy`:
  - 0xF0: set `brk`.
  - 0xE0: set `ext`.
  - Any other byte with `ext` set: ignored; clear `brk` and `ext`.
  - Other byte with `brk` set: if it equals `scan_code` and `key_down`=1, then `key_down`←0, `ascll`←0, `scan_code`←0, pulse `key_event`. Otherwise ignored. Clear `brk` in both cases.
  - Other byte, no flags, maps to a nonzero ASCII code: if it equals `scan_code` while `key_down`=1, it is typematic repeat and is ignored. Otherwise load `scan_code` and `ascll`, set `key_down`, pulse `key_event`. A new key therefore overrides the held one.
  - Unmapped make codes: ignored.
- Lookup (combinational):
  - Set-2 codes → lowercase a–z, digits 0–9, space.
  - Examples: 0x1C→0x61 'a', 0x15→0x71 'q', 0x16→0x31 '1', 0x45→0x30 '0', 0x29→0x20 ' '.
  - All other codes → 0.
- Reset: asynchronous, active-low. All outputs, flags, counters and the FSM go to 0/IDLE. A reset mid-frame discards the partial frame.

## Timing
- Reset values: `ascll`=0, `scan_code`=0, `key_down`=0, `key_event`=0, `frame_err`=0.
- Latency: edge detection happens 3 `clk` cycles after a raw `ps2_clk` fall (2 sync + 1 edge register). `byte_rdy` asserts 1 cycle after the stop-bit edge is detected. `ascll`, `scan_code`, `key_down` and `key_event` update on the following rising edge. Total: 5 `clk` cycles from the raw stop-bit fall.
- Pulse width: `key_event` and `frame_err` are exactly 1 `clk` wide. They never assert in the same cycle.
- Input rate: PS/2 clock is 10–16.7 kHz, so edges are ≥3000 `clk` apart and no input back-pressure exists.
- Output change: `ascll` changes only in the cycle `key_event` pulses.

## Structure
- Shared package, constants: `PS2_BREAK`=8'hF0, `PS2_EXT`=8'hE0, FSM state encoding (IDLE, RECV), frame length 11.
- Sub-module `ps2_scan_ascii`: pure combinational 8→8 lookup ROM, reusable by the text/VGA path.
- Top level: synchronizers, frame FSM and timeout counter, decoder registers.

## Test plan
- Reset: assert `reset_n`=0 mid-frame → all outputs 0. Send frame 0x1C after release → `ascll`=0x61, `key_down`=1, one `key_event`.
- Press/release: sequence 1C, F0 1C → `ascll` goes 0x61 then 0x00, with exactly 2 `key_event` pulses.
- Typematic and override: 1C 1C 1C 15, then F0 1C → `ascll`=0x71 and remains 0x71; 2 events total.
- Parity error: frame 0x16 with flipped parity → one `frame_err`, `ascll` unchanged. A correct 0x16 next → `ascll`=0x31.
- Timeout: stop `ps2_clk` after 5 bits for `TIMEOUT_CYCLES` cycles → one `frame_err`, FSM in IDLE. A full 0x29 frame next → `ascll`=0x20.
- Extended and unmapped: E0 75, F0 E0 75, then 0x05 (F1, unmapped) → no `key_event`, `ascll` stays 0.
